// File: rtl/arm_control_arbiter_if.sv
// AXI4-Lite bus between arm_control_arbiter (master) and the ARM_control
// register slave S00_AXI (slave). Signal names keep the legacy M_AXI_* form.
interface arm_control_arbiter_if #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
);
  logic [C_S_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR;
  logic [2:0]                        M_AXI_AWPROT;
  logic                              M_AXI_AWVALID;
  logic                              M_AXI_AWREADY;
  logic [C_S_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA;
  logic [C_S_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB;
  logic                              M_AXI_WVALID;
  logic                              M_AXI_WREADY;
  logic [1:0]                        M_AXI_BRESP;
  logic                              M_AXI_BVALID;
  logic                              M_AXI_BREADY;
  logic [C_S_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR;
  logic [2:0]                        M_AXI_ARPROT;
  logic                              M_AXI_ARVALID;
  logic                              M_AXI_ARREADY;
  logic [C_S_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA;
  logic [1:0]                        M_AXI_RRESP;
  logic                              M_AXI_RVALID;
  logic                              M_AXI_RREADY;

  modport master (
    output M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID,
    input  M_AXI_AWREADY,
    output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
    input  M_AXI_WREADY,
    input  M_AXI_BRESP, M_AXI_BVALID,
    output M_AXI_BREADY,
    output M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID,
    input  M_AXI_ARREADY,
    input  M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
    output M_AXI_RREADY
  );

  modport slave (
    input  M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID,
    output M_AXI_AWREADY,
    input  M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
    output M_AXI_WREADY,
    output M_AXI_BRESP, M_AXI_BVALID,
    input  M_AXI_BREADY,
    input  M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID,
    output M_AXI_ARREADY,
    output M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
    input  M_AXI_RREADY
  );
endinterface

// File: rtl/arm_control_arbiter.sv
// arm_control_arbiter: two-client round-robin arbiter that serialises single
// register read/write commands into single-beat AXI4-Lite transactions on the
// ARM_control register slave, returning data/response per client.
// Optional build macro ARB_ADDR_CHECK_EN: misaligned or out-of-range commands
// are answered locally with SLVERR and never reach the bus.
module arm_control_arbiter #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int NUM_REGS           = 4
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic [1:0]                      req_valid,
  input  logic [1:0]                      req_we,
  input  logic [2*C_S_AXI_ADDR_WIDTH-1:0] req_addr,
  input  logic [2*C_S_AXI_DATA_WIDTH-1:0] req_wdata,
  output logic [1:0]                      req_ready,
  output logic [1:0]                      rsp_valid,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]                      rsp_resp,
  arm_control_arbiter_if.master           m_axi
);

  localparam int AW = C_S_AXI_ADDR_WIDTH;
  localparam int DW = C_S_AXI_DATA_WIDTH;

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] WR   = 3'd1;
  localparam logic [2:0] WR_B = 3'd2;
  localparam logic [2:0] RD_A = 3'd3;
  localparam logic [2:0] RD_R = 3'd4;
  localparam logic [2:0] RSP  = 3'd5;

  logic [2:0]    state;
  logic          last_grant;
  logic          winner;
  logic [AW-3:0] cmd_idx;
  logic [DW-1:0] cmd_wdata;
  logic          awvalid_q;
  logic          wvalid_q;
  logic [DW-1:0] rdata_q;
  logic [1:0]    resp_q;
  logic          err_wait;

  logic          grant;
  logic          gnt_idx;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic          addr_bad;
  logic          aw_fin;
  logic          w_fin;

  // Round-robin pick: a lone requester wins; on a tie the client that did not
  // win last time goes first.
  always_comb begin
    gnt_idx   = 1'b0;
    req_ready = '0;
    if (req_valid == 2'b11) begin
      gnt_idx = ~last_grant;
    end else begin
      gnt_idx = req_valid[1];
    end
    grant = (state == IDLE) && (req_valid != 2'b00);
    if (grant) begin
      req_ready[gnt_idx] = 1'b1;
    end
    sel_we    = req_we[gnt_idx];
    sel_addr  = gnt_idx ? req_addr[2*AW-1:AW] : req_addr[AW-1:0];
    sel_wdata = gnt_idx ? req_wdata[2*DW-1:DW] : req_wdata[DW-1:0];
  end

`ifdef ARB_ADDR_CHECK_EN
  // Reject misaligned or unimplemented register addresses before the bus.
  always_comb begin
    addr_bad = (sel_addr[1:0] != 2'b00) ||
               (32'(sel_addr[AW-1:2]) >= 32'(NUM_REGS));
  end
`else
  // Every command is forwarded; the low address bits are simply dropped.
  logic unused_addr_chk;
  always_comb begin
    addr_bad        = 1'b0;
    unused_addr_chk = (^sel_addr[1:0]) ^ (32'(sel_addr[AW-1:2]) >= 32'(NUM_REGS));
  end
`endif

  // A side is finished once its VALID has dropped or is being accepted now,
  // which lets AW and W complete in either order or together.
  always_comb begin
    aw_fin = !awvalid_q || m_axi.M_AXI_AWREADY;
    w_fin  = !wvalid_q  || m_axi.M_AXI_WREADY;
  end

  // Sequencer: grant/capture, AXI write or read phases, then one response cycle.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      winner     <= 1'b0;
      cmd_idx    <= '0;
      cmd_wdata  <= '0;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      rdata_q    <= '0;
      resp_q     <= '0;
      err_wait   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant) begin
            last_grant <= gnt_idx;
            winner     <= gnt_idx;
            cmd_idx    <= sel_addr[AW-1:2];
            cmd_wdata  <= sel_wdata;
            rdata_q    <= '0;
            resp_q     <= 2'b00;
            if (addr_bad) begin
              // Rejected commands spend two cycles in RSP so the response
              // lands two cycles after the grant.
              resp_q   <= 2'b10;
              err_wait <= 1'b1;
              state    <= RSP;
            end else if (sel_we) begin
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              state     <= WR;
            end else begin
              state <= RD_A;
            end
          end
        end
        WR: begin
          if (awvalid_q && m_axi.M_AXI_AWREADY) begin
            awvalid_q <= 1'b0;
          end
          if (wvalid_q && m_axi.M_AXI_WREADY) begin
            wvalid_q <= 1'b0;
          end
          if (aw_fin && w_fin) begin
            state <= WR_B;
          end
        end
        WR_B: begin
          if (m_axi.M_AXI_BVALID) begin
            resp_q <= m_axi.M_AXI_BRESP;
            state  <= RSP;
          end
        end
        RD_A: begin
          if (m_axi.M_AXI_ARREADY) begin
            state <= RD_R;
          end
        end
        RD_R: begin
          if (m_axi.M_AXI_RVALID) begin
            rdata_q <= m_axi.M_AXI_RDATA;
            resp_q  <= m_axi.M_AXI_RRESP;
            state   <= RSP;
          end
        end
        RSP: begin
          if (err_wait) begin
            err_wait <= 1'b0;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Completion pulse to the winning client; data and response are registered.
  always_comb begin
    rsp_valid = '0;
    if ((state == RSP) && !err_wait) begin
      rsp_valid[winner] = 1'b1;
    end
    rsp_rdata = rdata_q;
    rsp_resp  = resp_q;
  end

  // AXI master outputs, all decoded from registers so no VALID depends on READY.
  always_comb begin
    m_axi.M_AXI_AWADDR  = {cmd_idx, 2'b00};
    m_axi.M_AXI_AWPROT  = 3'b000;
    m_axi.M_AXI_AWVALID = awvalid_q;
    m_axi.M_AXI_WDATA   = cmd_wdata;
    m_axi.M_AXI_WSTRB   = '1;
    m_axi.M_AXI_WVALID  = wvalid_q;
    m_axi.M_AXI_BREADY  = (state == WR_B);
    m_axi.M_AXI_ARADDR  = {cmd_idx, 2'b00};
    m_axi.M_AXI_ARPROT  = 3'b000;
    m_axi.M_AXI_ARVALID = (state == RD_A);
    m_axi.M_AXI_RREADY  = (state == RD_R);
  end

endmodule
